// File: rtl/xor_descrambler_pkg.sv
// Shared types and constants for the XOR descrambler and its keystream step.
package xor_pkg;

  // Receive framing states: hunt for sync, collect the two seed nibbles, then payload.
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    SEED_HI = 2'd1,
    SEED_LO = 2'd2,
    PAYLOAD = 2'd3
  } state_t;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in this shift direction: s[7]^s[5]^s[4]^s[3].
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // An all-zero state would lock the LFSR, so a zero seed is replaced by this value.
  localparam logic [7:0] ZERO_SEED_SUB = 8'hFF;

  // LFSR value after reset.
  localparam logic [7:0] LFSR_RESET = 8'hFF;

  // Replace the degenerate all-zero seed.
  function automatic logic [7:0] fix_seed(input logic [7:0] seed);
    return (seed == 8'h00) ? ZERO_SEED_SUB : seed;
  endfunction

endpackage

// File: rtl/xor_descrambler_lfsr4_step.sv
// Combinational four-step advance of the 8-bit Fibonacci LFSR.
// Returns {state after 4 steps, K[3:0]} with K[3] being the first bit shifted out.
module lfsr4_step
  import xor_pkg::*;
(
  input  logic [7:0]  state_in,
  output logic [11:0] step_out
);

  logic [7:0] s;
  logic [3:0] k;

  // Step the register four times, collecting the output bit MSB-first.
  always_comb begin
    s = state_in;
    k = 4'h0;
    for (int i = 0; i < 4; i++) begin
      k = {k[2:0], s[7]};
      s = {s[6:0], ^(s & LFSR_TAPS)};
    end
    step_out = {s, k};
  end

endmodule

// File: rtl/xor_descrambler.sv
// Receive-side XOR descrambler: hunts for a sync nibble, loads an 8-bit LFSR
// seed from a two-nibble header and descrambles a fixed-length payload.
// C2 = 0 turns the block into a registered pass-through.
module xor_descrambler
  import xor_pkg::*;
#(
  parameter int         FRAME_LEN = 8,
  parameter logic [3:0] SYNC      = 4'hA
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       C2,
  input  logic [3:0] Z,
  input  logic       valid_in,
  output logic [3:0] A,
  output logic       valid_out,
  output logic       locked,
  output logic       frame_done
);

  localparam logic [7:0] LAST_COUNT = 8'(FRAME_LEN - 1);

  state_t     state, next_state;
  logic [7:0] lfsr, next_lfsr;
  logic [7:0] count, next_count;
  logic [3:0] seed_hi, next_seed_hi;
  logic [3:0] next_a;
  logic       next_valid;
  logic       next_done;

  logic [11:0] step_out;
  logic [7:0]  lfsr_adv;
  logic [3:0]  keystream;

  lfsr4_step u_step (
    .state_in (lfsr),
    .step_out (step_out)
  );

  assign lfsr_adv  = step_out[11:4];
  assign keystream = step_out[3:0];

  // Next-state and next-output logic; nothing advances unless a nibble is accepted.
  always_comb begin
    next_state   = state;
    next_lfsr    = lfsr;
    next_count   = count;
    next_seed_hi = seed_hi;
    next_a       = A;
    next_valid   = 1'b0;
    next_done    = 1'b0;
    if (!C2) begin
      // Bypass: straight registered copy, framing abandoned, LFSR left untouched.
      next_state = HUNT;
      next_a     = Z;
      next_valid = valid_in;
    end else if (valid_in) begin
      case (state)
        HUNT: begin
          if (Z == SYNC) begin
            next_state = SEED_HI;
          end else begin
            next_state = HUNT;
          end
        end
        SEED_HI: begin
          next_seed_hi = Z;
          next_state   = SEED_LO;
        end
        SEED_LO: begin
          next_lfsr  = fix_seed({seed_hi, Z});
          next_count = 8'd0;
          next_state = PAYLOAD;
        end
        PAYLOAD: begin
          next_a     = Z ^ keystream;
          next_valid = 1'b1;
          next_lfsr  = lfsr_adv;
          if (count == LAST_COUNT) begin
            next_state = HUNT;
            next_done  = 1'b1;
          end else begin
            next_count = count + 8'd1;
          end
        end
        default: begin
          next_state = HUNT;
        end
      endcase
    end else begin
      next_state = state;
    end
  end

  // Framing state, keystream register and payload counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HUNT;
      lfsr    <= LFSR_RESET;
      count   <= 8'd0;
      seed_hi <= 4'h0;
    end else begin
      state   <= next_state;
      lfsr    <= next_lfsr;
      count   <= next_count;
      seed_hi <= next_seed_hi;
    end
  end

  // Registered outputs; locked follows the state being entered so it moves on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A          <= 4'h0;
      valid_out  <= 1'b0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      A          <= next_a;
      valid_out  <= next_valid;
      locked     <= (next_state == PAYLOAD);
      frame_done <= next_done;
    end
  end

endmodule

// File: tb/tb_xor_descrambler.sv
// Self-checking bench for xor_descrambler: directed cases from the test plan
// followed by randomized framed traffic against a behavioural model.
module tb_xor_descrambler;

  localparam int         FL   = 2;
  localparam logic [3:0] SYNC = 4'hA;

  logic       clk = 1'b0;
  logic       rst;
  logic       C2;
  logic [3:0] Z;
  logic       valid_in;
  logic [3:0] A;
  logic       valid_out;
  logic       locked;
  logic       frame_done;

  int nvec = 0;
  int nchk = 0;
  int miscompares = 0;

  // Reference model state
  int         m_phase;   // 0 waiting for sync, 1 seed high, 2 seed low, 3 payload
  logic [7:0] m_seed;
  logic       m_ks [0:4*FL-1];
  int         m_idx;
  logic [3:0] e_a;
  logic       e_v;
  logic       e_locked;
  logic       e_done;

  xor_descrambler #(.FRAME_LEN(FL), .SYNC(SYNC)) dut (
    .clk        (clk),
    .rst        (rst),
    .C2         (C2),
    .Z          (Z),
    .valid_in   (valid_in),
    .A          (A),
    .valid_out  (valid_out),
    .locked     (locked),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_idx    = 0;
    e_a      = 4'h0;
    e_v      = 1'b0;
    e_locked = 1'b0;
    e_done   = 1'b0;
  endtask

  // Build the whole frame's keystream bit by bit from the seed.
  task automatic gen_keystream(input logic [7:0] seed);
    logic [7:0] s;
    logic       fb;
    s = (seed == 8'h00) ? 8'hFF : seed;
    for (int b = 0; b < 4*FL; b++) begin
      m_ks[b] = s[7];
      fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      s = {s[6:0], fb};
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (!C2) begin
      e_a    = Z;
      e_v    = valid_in;
      e_done = 1'b0;
      m_phase = 0;
    end else begin
      e_v    = 1'b0;
      e_done = 1'b0;
      if (valid_in) begin
        if (m_phase == 0) begin
          if (Z == SYNC) m_phase = 1;
        end else if (m_phase == 1) begin
          m_seed[7:4] = Z;
          m_phase = 2;
        end else if (m_phase == 2) begin
          m_seed[3:0] = Z;
          gen_keystream(m_seed);
          m_idx = 0;
          m_phase = 3;
        end else begin
          e_a = Z ^ {m_ks[4*m_idx], m_ks[4*m_idx+1], m_ks[4*m_idx+2], m_ks[4*m_idx+3]};
          e_v = 1'b1;
          m_idx++;
          if (m_idx == FL) begin
            m_phase = 0;
            e_done  = 1'b1;
          end
        end
      end
    end
    e_locked = (m_phase == 3);
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".valid_out"}, {7'd0, valid_out}, {7'd0, e_v});
    check_eq({tag, ".locked"}, {7'd0, locked}, {7'd0, e_locked});
    check_eq({tag, ".frame_done"}, {7'd0, frame_done}, {7'd0, e_done});
    if (e_v) check_eq({tag, ".A"}, {4'd0, A}, {4'd0, e_a});
  endtask

  // Apply one cycle of inputs, advance the model at the edge and compare just after it.
  task automatic cyc(input logic c2_i, input logic vin_i, input logic [3:0] z_i, input string tag);
    C2 = c2_i;
    valid_in = vin_i;
    Z = z_i;
    @(posedge clk);
    model_step();
    #1;
    nvec++;
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    C2 = 1'b1;
    valid_in = 1'b0;
    Z = 4'h0;
    model_reset();
    cyc(1'b1, 1'b1, 4'hA, "rst_hold");
    check_eq("rst.A", {4'd0, A}, 8'h00);
    #2;
    rst = 1'b0;

    // Seed FF: keystream F,F so payload F,F recovers 0,0
    cyc(1'b1, 1'b1, 4'hA, "ff_sync");
    cyc(1'b1, 1'b1, 4'hF, "ff_hi");
    cyc(1'b1, 1'b1, 4'hF, "ff_lo");
    check_eq("ff.locked_up", {7'd0, locked}, 8'h01);
    cyc(1'b1, 1'b1, 4'hF, "ff_p0");
    check_eq("ff.A0", {4'd0, A}, 8'h00);
    check_eq("ff.locked_p0", {7'd0, locked}, 8'h01);
    cyc(1'b1, 1'b1, 4'hF, "ff_p1");
    check_eq("ff.A1", {4'd0, A}, 8'h00);
    check_eq("ff.done", {7'd0, frame_done}, 8'h01);

    // Seed 01 back-to-back: keystream 0,1 so payload 5,5 recovers 5,4
    cyc(1'b1, 1'b1, 4'hA, "s01_sync");
    cyc(1'b1, 1'b1, 4'h0, "s01_hi");
    cyc(1'b1, 1'b1, 4'h1, "s01_lo");
    cyc(1'b1, 1'b1, 4'h5, "s01_p0");
    check_eq("s01.A0", {4'd0, A}, 8'h05);
    cyc(1'b1, 1'b1, 4'h5, "s01_p1");
    check_eq("s01.A1", {4'd0, A}, 8'h04);
    check_eq("s01.done", {7'd0, frame_done}, 8'h01);
    check_eq("s01.unlock", {7'd0, locked}, 8'h00);
    cyc(1'b1, 1'b0, 4'h0, "s01_idle");
    check_eq("s01.done_pulse", {7'd0, frame_done}, 8'h00);

    // Hunt discards junk; stalls in payload do not advance the keystream
    cyc(1'b1, 1'b1, 4'h3, "hunt_j0");
    cyc(1'b1, 1'b1, 4'h7, "hunt_j1");
    cyc(1'b1, 1'b1, 4'hA, "hunt_sync");
    cyc(1'b1, 1'b0, 4'hA, "hunt_gap0");
    cyc(1'b1, 1'b1, 4'h0, "hunt_hi");
    cyc(1'b1, 1'b1, 4'h1, "hunt_lo");
    cyc(1'b1, 1'b1, 4'h5, "hunt_p0");
    check_eq("hunt.A0", {4'd0, A}, 8'h05);
    cyc(1'b1, 1'b0, 4'h9, "hunt_gap1");
    cyc(1'b1, 1'b0, 4'h2, "hunt_gap2");
    cyc(1'b1, 1'b1, 4'h5, "hunt_p1");
    check_eq("hunt.A1", {4'd0, A}, 8'h04);

    // Bypass
    cyc(1'b0, 1'b1, 4'h6, "byp0");
    check_eq("byp.A0", {4'd0, A}, 8'h06);
    cyc(1'b0, 1'b1, 4'hE, "byp1");
    check_eq("byp.A1", {4'd0, A}, 8'h0E);

    // Drop C2 mid-frame
    cyc(1'b1, 1'b1, 4'hA, "drop_sync");
    cyc(1'b1, 1'b1, 4'h0, "drop_hi");
    cyc(1'b1, 1'b1, 4'h1, "drop_lo");
    cyc(1'b1, 1'b1, 4'h5, "drop_p0");
    cyc(1'b0, 1'b0, 4'h5, "drop_off");
    check_eq("drop.locked", {7'd0, locked}, 8'h00);
    check_eq("drop.done", {7'd0, frame_done}, 8'h00);
    cyc(1'b1, 1'b1, 4'h5, "drop_back");
    check_eq("drop.hunt_noval", {7'd0, valid_out}, 8'h00);

    // Zero seed behaves like seed FF
    cyc(1'b1, 1'b1, 4'hA, "z_sync");
    cyc(1'b1, 1'b1, 4'h0, "z_hi");
    cyc(1'b1, 1'b1, 4'h0, "z_lo");
    cyc(1'b1, 1'b1, 4'hF, "z_p0");
    check_eq("zero.A0", {4'd0, A}, 8'h00);
    cyc(1'b1, 1'b1, 4'hF, "z_p1");

    // Asynchronous reset mid-frame
    cyc(1'b1, 1'b1, 4'hA, "ar_sync");
    cyc(1'b1, 1'b1, 4'hF, "ar_hi");
    cyc(1'b1, 1'b1, 4'hF, "ar_lo");
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("arst.locked", {7'd0, locked}, 8'h00);
    check_eq("arst.valid", {7'd0, valid_out}, 8'h00);
    check_eq("arst.A", {4'd0, A}, 8'h00);
    check_eq("arst.done", {7'd0, frame_done}, 8'h00);
    cyc(1'b1, 1'b1, 4'hF, "arst_hold");
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b1, 4'hF, "arst_after");
    check_eq("arst.noval", {7'd0, valid_out}, 8'h00);

    // Randomized framed traffic with stalls and occasional bypass excursions
    for (int n = 0; n < 600; n++) begin
      logic       c2_r;
      logic       v_r;
      logic [3:0] z_r;
      c2_r = ($urandom_range(0, 19) != 0);
      v_r  = ($urandom_range(0, 3) != 0);
      z_r  = ($urandom_range(0, 2) == 0) ? SYNC : 4'($urandom_range(0, 15));
      cyc(c2_r, v_r, z_r, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

endmodule
